feed_frame_assembler: RTL and testbench
=======================================

# feed_frame_assembler

Assembles fixed-length market-feed order messages from a 64-bit beat stream into the 320-bit `ff_buffer` word consumed by the parser stage. Sits directly upstream of the parser, between the network receive path and order decode. Validates frame length and request type, drops bad frames with a saturating drop count, and holds each good message stable under a valid/ready handshake.

## Interface
- `BEATS`, 5, beats per message; message width is `BEATS*W`.
- `W`, 64, beat width in bits.
- `CNT_W`, 16, drop-counter width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_data`  in  W  stream beat; first message byte is in `[W-1:W-8]`.
- `s_valid`  in  1  beat valid.
- `s_last`  in  1  final beat of the frame.
- `s_ready`  out  1  beat accepted when `s_valid && s_ready`.
- `ff_buffer`  out  BEATS*W  assembled message; `req_type` is `[319:312]`.
- `buf_valid`  out  1  `ff_buffer` holds an undelivered message.
- `buf_ready`  in  1  consumer takes the message when `buf_valid && buf_ready`.
- `drop_count`  out  CNT_W  saturating count of dropped frames.
- `frame_error`  out  1  one-cycle pulse on a length error.

## Operation
- Reset values:
  - state COLLECT, beat count 0, assembly register 0;
  - `ff_buffer` 0, `buf_valid` 0, `drop_count` 0, `frame_error` 0.
- Reset mid-frame discards the partial message and any held output.
- Beat placement: accepted beat k (0-based) is written to bits `[W*(BEATS-k)-1 : W*(BEATS-k-1)]`. Beat 0 therefore lands in `[319:256]`.
- `s_ready` is 1 in COLLECT and DISCARD, and 0 in HOLD. It is registered and never depends combinationally on `buf_ready`.
- COLLECT, on an accepted beat:
  - count < BEATS-1 and `!s_last`: store the beat, count+1.
  - count < BEATS-1 and `s_last` (short frame): drop the frame, pulse `frame_error`, increment `drop_count`, count = 0, stay in COLLECT.
  - count == BEATS-1 and `!s_last` (long frame): drop the frame, pulse `frame_error`, increment `drop_count`, go to DISCARD.
  - count == BEATS-1 and `s_last` (complete frame), request type is S (8'h53), D (8'h44) or E (8'h45), and the output slot is free: load `ff_buffer`, count = 0.
  - Complete frame with a valid type, slot busy: go to HOLD.
  - Complete frame with any other type: drop it, increment `drop_count`, no `frame_error`, count = 0.
- Slot free means `!buf_valid || buf_ready` in the same cycle. This allows back-to-back delivery without a bubble.
- HOLD: assembly register frozen. When `buf_ready && buf_valid`, transfer the message to `ff_buffer`, keep `buf_valid` = 1, and return to COLLECT.
- DISCARD: accept and drop beats until an accepted beat with `s_last`, then go to COLLECT with count 0. There is no further count or error for that frame.
- `buf_valid` clears on a handshake unless a new message loads in the same cycle.
- `ff_buffer` is stable while `buf_valid && !buf_ready`.
- `drop_count` saturates at all-ones. At most one drop event can occur per cycle.

## Timing
- Latency: `buf_valid` rises on the cycle after the final beat is accepted.
- Throughput: one message per BEATS cycles with `buf_ready` held high.
- `frame_error` is asserted for exactly the cycle after the offending beat.
- A HOLD exit re-opens `s_ready` on the cycle after the consuming handshake.
- `s_valid` without `s_ready` has no effect. Upstream holds `s_data` and `s_last` until accepted.

## Structure
- Shared package `hft_pkg` holds:
  - request-type constants `REQ_TYPE_ADD`, `REQ_TYPE_DELETE`, `REQ_TYPE_DECREASE`;
  - message width 320 and field offsets (`req_type`, `order_id`, `stock_id`, `side`, `quantity`, `price`);
  - the assembler state enum (COLLECT, HOLD, DISCARD).
- The parser imports the same constants.
- One natural sub-module: `sat_counter` (parameterised width, increment enable, synchronous active-low reset), used for `drop_count`.

## Test plan
- Good ADD frame: 5 beats, beat0 = 64'h5300_0000_0000_0001, `s_last` on beat 5, `buf_ready` = 1. Expect `buf_valid` the next cycle, `ff_buffer[319:312]` = 8'h53, `ff_buffer[319:256]` equal to beat0, `drop_count` 0.
- Backpressure: `buf_ready` = 0, send two good frames. Expect the second to enter HOLD with `s_ready` = 0. On a one-cycle `buf_ready` pulse, frame 1 is consumed and frame 2 appears the next cycle with `buf_valid` still 1. Order is preserved.
- Short frame: `s_last` on beat 3. Expect a one-cycle `frame_error`, `drop_count` = 1, no `buf_valid`. The following good frame is delivered intact.
- Long frame: 7 beats, `s_last` on beat 7. Expect `frame_error` after beat 5, beats 6–7 accepted and dropped, `drop_count` = 1. The next frame is delivered.
- Unknown type: beat0 MSB byte 8'h58. Expect a drop with `drop_count` +1, `frame_error` 0, `buf_valid` 0.
- Reset mid-frame after 2 beats, then a good DELETE frame: the frame is delivered with `[319:312]` = 8'h44.
- Saturation with `CNT_W` = 2: 5 drops give `drop_count` = 3.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared market-feed constants: request types, order message layout, assembler states.
// Imported by the frame assembler and the parser so both agree on field positions.
package hft_pkg;
  localparam int MSG_W = 320;

  localparam logic [7:0] REQ_TYPE_ADD      = 8'h53;
  localparam logic [7:0] REQ_TYPE_DELETE   = 8'h44;
  localparam logic [7:0] REQ_TYPE_DECREASE = 8'h45;

  // Field LSB offsets and widths inside the message; req_type sits in the top byte
  localparam int REQ_TYPE_LSB = 312;
  localparam int REQ_TYPE_W   = 8;
  localparam int ORDER_ID_LSB = 248;
  localparam int ORDER_ID_W   = 64;
  localparam int STOCK_ID_LSB = 216;
  localparam int STOCK_ID_W   = 32;
  localparam int SIDE_LSB     = 208;
  localparam int SIDE_W       = 8;
  localparam int QUANTITY_LSB = 176;
  localparam int QUANTITY_W   = 32;
  localparam int PRICE_LSB    = 112;
  localparam int PRICE_W      = 64;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  function automatic logic is_req_type(input logic [7:0] t);
    return (t == REQ_TYPE_ADD) || (t == REQ_TYPE_DELETE) || (t == REQ_TYPE_DECREASE);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments by one per enabled cycle, sticks at all-ones.
// Count is visible the cycle after the enable; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/feed_frame_assembler.sv
// Packs BEATS stream beats into one order message, drops malformed frames, counts drops.
// buf_valid rises the cycle after the final beat; s_ready drops only while a second message waits for the slot.
module feed_frame_assembler
  import hft_pkg::*;
#(
  parameter int BEATS = 5,
  parameter int W     = 64,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [BEATS*W-1:0]   ff_buffer,
  output logic                 buf_valid,
  input  logic                 buf_ready,
  output logic [CNT_W-1:0]     drop_count,
  output logic                 frame_error
);
  localparam int MSG_BITS = BEATS * W;
  localparam int CW       = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  logic [1:0]          state, state_nxt;
  logic [CW-1:0]       beat_cnt, beat_cnt_nxt;
  logic [MSG_BITS-1:0] asm_reg, asm_placed;
  logic                accept, slot_free, at_last, type_ok;
  logic                load_new, load_held, drop_evt, len_err, store_beat;

  assign accept    = s_valid && s_ready;
  assign slot_free = !buf_valid || buf_ready;
  assign at_last   = (beat_cnt == LAST_IDX);
  // Beat 0 is already in the assembly register by the time the last beat arrives
  assign type_ok   = is_req_type(asm_reg[MSG_BITS-1 -: 8]);

  always_comb begin
    asm_placed = asm_reg;
    asm_placed[(BEATS - 1 - int'(beat_cnt)) * W +: W] = s_data;
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    load_new     = 1'b0;
    load_held    = 1'b0;
    drop_evt     = 1'b0;
    len_err      = 1'b0;
    store_beat   = 1'b0;
    case (state)
      ST_COLLECT: begin
        if (accept) begin
          if (!at_last) begin
            if (s_last) begin
              len_err      = 1'b1;
              drop_evt     = 1'b1;
              beat_cnt_nxt = '0;
            end else begin
              store_beat   = 1'b1;
              beat_cnt_nxt = beat_cnt + 1'b1;
            end
          end else if (!s_last) begin
            len_err      = 1'b1;
            drop_evt     = 1'b1;
            beat_cnt_nxt = '0;
            state_nxt    = ST_DISCARD;
          end else if (!type_ok) begin
            drop_evt     = 1'b1;
            beat_cnt_nxt = '0;
          end else begin
            // Keep the full message in the assembly register in case it has to wait in HOLD
            store_beat   = 1'b1;
            beat_cnt_nxt = '0;
            if (slot_free) load_new = 1'b1;
            else           state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (buf_valid && buf_ready) begin
          load_held = 1'b1;
          state_nxt = ST_COLLECT;
        end
      end
      ST_DISCARD: begin
        if (accept && s_last) state_nxt = ST_COLLECT;
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_COLLECT;
      beat_cnt    <= '0;
      asm_reg     <= '0;
      ff_buffer   <= '0;
      buf_valid   <= 1'b0;
      s_ready     <= 1'b1;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      beat_cnt    <= beat_cnt_nxt;
      frame_error <= len_err;
      s_ready     <= (state_nxt != ST_HOLD);
      if (store_beat) asm_reg <= asm_placed;
      if (load_new) begin
        ff_buffer <= asm_placed;
        buf_valid <= 1'b1;
      end else if (load_held) begin
        ff_buffer <= asm_reg;
        buf_valid <= 1'b1;
      end else if (buf_valid && buf_ready) begin
        buf_valid <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_evt),
    .count (drop_count)
  );
endmodule

// File: tb/tb_feed_frame_assembler.sv
// Bench for feed_frame_assembler: directed sequences, a frame table and random traffic
// against a frame-level scoreboard; a second instance with a 2-bit drop counter runs in parallel.
module tb_feed_frame_assembler;
  localparam int BEATS = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         buf_ready = 1'b0;
  logic         s_ready, buf_valid, frame_error;
  logic [319:0] ff_buffer;
  logic [15:0]  drop_count;
  logic         s_ready2, buf_valid2, frame_error2;
  logic [319:0] ff_buffer2;
  logic [1:0]   drop_count2;

  always #5 clk = ~clk;

  feed_frame_assembler dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .ff_buffer(ff_buffer), .buf_valid(buf_valid), .buf_ready(buf_ready),
    .drop_count(drop_count), .frame_error(frame_error)
  );

  feed_frame_assembler #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready2), .ff_buffer(ff_buffer2), .buf_valid(buf_valid2), .buf_ready(buf_ready),
    .drop_count(drop_count2), .frame_error(frame_error2)
  );

  int n_checks = 0, n_pass = 0;

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check_v(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Frame-level reference: beats of the frame in flight, messages owed to the consumer
  logic [63:0]  cur[$];
  logic [319:0] exp_msgs[$];
  int exp_drops = 0, exp_errs = 0, seen_errs = 0, delivered = 0;
  logic         hold_prev = 1'b0, last_acc = 1'b0, rand_br = 1'b0;
  logic [319:0] buf_prev = '0;

  task automatic model_beat(input logic [63:0] d, input logic last);
    logic [319:0] m;
    cur.push_back(d);
    if (last) begin
      if (cur.size() != BEATS) begin
        exp_drops++;
        exp_errs++;
      end else if (cur[0][63:56] inside {8'h53, 8'h44, 8'h45}) begin
        m = '0;
        foreach (cur[i]) m = {m[255:0], cur[i]};
        exp_msgs.push_back(m);
      end else begin
        exp_drops++;
      end
      cur.delete();
    end
  endtask

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // One clock: score handshakes seen at the edge, then sample #1 after it
  task automatic step();
    logic acc, take;
    if (rand_br) buf_ready = 1'($urandom_range(1));
    acc  = s_valid && s_ready;
    take = buf_valid && buf_ready;
    if (take) begin
      check_b("msg_expected", exp_msgs.size() != 0, 1'b1);
      if (exp_msgs.size() != 0) check_v("msg_data", ff_buffer, exp_msgs.pop_front());
      delivered++;
    end
    hold_prev = buf_valid && !buf_ready;
    buf_prev  = ff_buffer;
    if (acc) model_beat(s_data, s_last);
    last_acc = acc;
    @(posedge clk);
    #1;
    if (frame_error) seen_errs++;
    if (hold_prev) check_v("buf_stable", {319'b0, buf_valid} ^ (ff_buffer << 1), {319'b0, 1'b1} ^ (buf_prev << 1));
  endtask

  task automatic wait_accept();
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while (!last_acc && guard < 200);
    if (!last_acc) check_b("accept_timeout", last_acc, 1'b1);
  endtask

  task automatic send_frame(input int nbeats, input logic [7:0] typ, input int gap_pct);
    logic [63:0] b;
    for (int i = 0; i < nbeats; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0;
        step();
      end
      b = {$urandom, $urandom};
      if (i == 0) b[63:56] = typ;
      s_valid = 1'b1;
      s_data  = b;
      s_last  = (i == nbeats - 1);
      wait_accept();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; buf_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cur.delete();
    exp_msgs.delete();
    exp_drops = 0; exp_errs = 0; seen_errs = 0; hold_prev = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         nbeats;
    logic [7:0] typ;
    int         deliv;
    int         drops;
    int         errs;
  } vec_t;
  vec_t vecs[11];

  initial begin
    logic [63:0]  beat0;
    logic [319:0] bmsg;
    int d0, dc0, e0, nb, guard;
    logic [7:0] ty;

    vecs[0]  = '{5, 8'h53, 1, 0, 0};
    vecs[1]  = '{5, 8'h44, 1, 0, 0};
    vecs[2]  = '{3, 8'h53, 0, 1, 1};
    vecs[3]  = '{5, 8'h45, 1, 0, 0};
    vecs[4]  = '{7, 8'h53, 0, 1, 1};
    vecs[5]  = '{5, 8'h53, 1, 0, 0};
    vecs[6]  = '{5, 8'h58, 0, 1, 0};
    vecs[7]  = '{1, 8'h53, 0, 1, 1};
    vecs[8]  = '{6, 8'h44, 0, 1, 1};
    vecs[9]  = '{5, 8'h44, 1, 0, 0};
    vecs[10] = '{5, 8'h00, 0, 1, 0};

    do_reset();
    check_b("rst_buf_valid", buf_valid, 1'b0);
    check_b("rst_frame_error", frame_error, 1'b0);
    check_b("rst_s_ready", s_ready, 1'b1);
    check_v("rst_ff_buffer", ff_buffer, '0);
    check_i("rst_drop_count", int'(drop_count), 0);
    check_i("rst_drop_count_sat", int'(drop_count2), 0);

    // Good ADD frame and its one-cycle latency
    buf_ready = 1'b1;
    beat0 = 64'h5300_0000_0000_0001;
    for (int i = 0; i < BEATS; i++) begin
      s_valid = 1'b1;
      s_data  = (i == 0) ? beat0 : {32'hA0A0_0000, 32'(i)};
      s_last  = (i == BEATS - 1);
      wait_accept();
      if (i == BEATS - 2) check_b("add_no_early_valid", buf_valid, 1'b0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    check_b("add_buf_valid", buf_valid, 1'b1);
    check_v("add_req_type", {312'b0, ff_buffer[319:312]}, {312'b0, 8'h53});
    check_v("add_beat0", {256'b0, ff_buffer[319:256]}, {256'b0, beat0});
    check_i("add_drop_count", int'(drop_count), 0);
    step(); step();

    // Backpressure: second frame parks in HOLD until the slot frees
    buf_ready = 1'b0;
    send_frame(5, 8'h53, 0);
    send_frame(5, 8'h45, 0);
    check_b("bp_hold_s_ready", s_ready, 1'b0);
    check_i("bp_two_pending", exp_msgs.size(), 2);
    check_v("bp_first_on_buf", ff_buffer, exp_msgs[0]);
    bmsg = exp_msgs[1];
    repeat (3) step();
    check_b("bp_still_held", s_ready, 1'b0);
    buf_ready = 1'b1;
    step();
    buf_ready = 1'b0;
    check_b("bp_valid_kept", buf_valid, 1'b1);
    check_v("bp_second_msg", ff_buffer, bmsg);
    check_b("bp_s_ready_reopen", s_ready, 1'b1);
    buf_ready = 1'b1;
    step(); step();
    check_b("bp_drained", buf_valid, 1'b0);

    for (int i = 0; i < 11; i++) begin
      d0 = delivered; dc0 = int'(drop_count); e0 = seen_errs;
      send_frame(vecs[i].nbeats, vecs[i].typ, 0);
      step(); step();
      check_i($sformatf("vec%0d_delivered", i), delivered - d0, vecs[i].deliv);
      check_i($sformatf("vec%0d_drops", i), int'(drop_count) - dc0, vecs[i].drops);
      check_i($sformatf("vec%0d_errors", i), seen_errs - e0, vecs[i].errs);
      check_i($sformatf("vec%0d_drop_sat", i), int'(drop_count2), sat3(exp_drops));
    end

    // Reset in the middle of a frame, then a DELETE frame
    s_valid = 1'b1; s_data = {8'h53, 56'h1}; s_last = 1'b0;
    wait_accept();
    s_data = 64'h2;
    wait_accept();
    do_reset();
    check_b("mid_rst_buf_valid", buf_valid, 1'b0);
    check_i("mid_rst_drop_count", int'(drop_count), 0);
    buf_ready = 1'b1;
    send_frame(5, 8'h44, 0);
    check_b("del_buf_valid", buf_valid, 1'b1);
    check_v("del_req_type", {312'b0, ff_buffer[319:312]}, {312'b0, 8'h44});
    step(); step();
    check_i("del_drop_count", int'(drop_count), 0);

    // Random traffic with random consumer stalls
    rand_br = 1'b1;
    for (int f = 0; f < 300; f++) begin
      case ($urandom_range(9))
        6:       nb = int'($urandom_range(1, 4));
        7:       nb = int'($urandom_range(6, 8));
        default: nb = BEATS;
      endcase
      case ($urandom_range(4))
        0:       ty = 8'h53;
        1:       ty = 8'h44;
        2:       ty = 8'h45;
        3:       ty = 8'h58;
        default: ty = 8'($urandom);
      endcase
      send_frame(nb, ty, 20);
    end
    rand_br = 1'b0;
    buf_ready = 1'b1;
    guard = 0;
    while (exp_msgs.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    step(); step();
    check_i("rand_all_delivered", exp_msgs.size(), 0);
    check_b("rand_buf_idle", buf_valid, 1'b0);
    check_i("rand_drop_count", int'(drop_count), exp_drops);
    check_i("rand_drop_sat", int'(drop_count2), sat3(exp_drops));
    check_i("rand_frame_errors", seen_errs, exp_errs);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
